// File: rtl/flop_stim_gen.sv
// Purpose: drives a registered stimulus pattern (hold/invert/LFSR/walking-one) into a flop array and counts bit toggles.
// Latency: D loads one edge after START is accepted, then changes once per cycle for NCYC cycles; DONE follows the last update.
// Backpressure: none; STOP aborts a run immediately, and START is honoured only while idle.
module flop_stim_gen #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic [15:0]      SEED,
  input  logic [15:0]      NCYC,
  output logic [WIDTH-1:0] D,
  output logic             BUSY,
  output logic             DONE,
  output logic [19:0]      TOGGLES
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } state_t;

  localparam logic [15:0] lfsr_default = 16'hACE1;

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [1:0]       mode_q;
  logic [15:0]      cnt;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_seed;
  logic [15:0]      lfsr_step;
  logic [WIDTH-1:0] init_dat;
  logic [WIDTH-1:0] next_dat;
  logic             accept;
  logic             update;

  // count of set bits, used to accumulate toggles per update
  function automatic logic [4:0] popcnt(input logic [WIDTH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  assign accept    = (state == st_idle) && START;
  assign update    = (state == st_run) && !STOP;
  // an all-zero LFSR would lock up, so a zero seed falls back to the default
  assign lfsr_seed = (SEED == 16'd0) ? lfsr_default : SEED;
  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // pattern value loaded at acceptance, selected by the incoming MODE
  always_comb begin
    init_dat = '0;
    case (MODE)
      2'b00, 2'b01: init_dat = SEED[WIDTH-1:0];
      2'b10:        init_dat = lfsr_seed[WIDTH-1:0];
      default:      init_dat = WIDTH'(1);
    endcase
  end

  // pattern value for the next update, selected by the latched mode
  always_comb begin
    next_dat = D;
    case (mode_q)
      2'b00:   next_dat = D;
      2'b01:   next_dat = ~D;
      2'b10:   next_dat = lfsr_step[WIDTH-1:0];
      // shifting both ways keeps the rotate correct even for WIDTH=1
      default: next_dat = (D << 1) | (D >> (WIDTH - 1));
    endcase
  end

  // state register with registered BUSY/DONE flags
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state <= st_idle;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: begin
        if (START) begin
          state_nxt = (NCYC != 16'd0) ? st_run : st_done;
        end
      end
      st_run: begin
        if (STOP) begin
          state_nxt = st_idle;
        end else if (cnt == 16'd1) begin
          state_nxt = st_done;
        end
      end
      st_done: state_nxt = st_idle;
      default: state_nxt = st_idle;
    endcase
  end

  // flag values for the state being entered, so the flags line up with it
  always_comb begin
    busy_nxt = (state_nxt == st_run);
    done_nxt = (state_nxt == st_done);
  end

  // datapath: load on acceptance, step on each run update, hold otherwise
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      D       <= '0;
      TOGGLES <= '0;
      cnt     <= '0;
      lfsr    <= lfsr_default;
      mode_q  <= 2'b00;
    end else if (accept) begin
      mode_q  <= MODE;
      cnt     <= NCYC;
      TOGGLES <= '0;
      D       <= init_dat;
      lfsr    <= lfsr_seed;
    end else if (update) begin
      D       <= next_dat;
      TOGGLES <= TOGGLES + 20'(popcnt(D ^ next_dat));
      cnt     <= cnt - 16'd1;
      if (mode_q == 2'b10) begin
        lfsr <= lfsr_step;
      end
    end
  end

endmodule

// File: tb/tb_flop_stim_gen.sv
// Directed bench for flop_stim_gen: expected D values are queued as each run is launched and popped cycle by cycle.
module tb_flop_stim_gen;

  logic        CLK;
  logic        RSTB;
  logic        START;
  logic        STOP;
  logic [1:0]  MODE;
  logic [15:0] SEED;
  logic [15:0] NCYC;
  logic [7:0]  D;
  logic        BUSY;
  logic        DONE;
  logic [19:0] TOGGLES;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  flop_stim_gen #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RSTB    (RSTB),
    .START   (START),
    .STOP    (STOP),
    .MODE    (MODE),
    .SEED    (SEED),
    .NCYC    (NCYC),
    .D       (D),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .TOGGLES (TOGGLES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pop the next expected D value; an empty queue counts as a failure
  task automatic pop_chk(input string tag, output logic [7:0] last);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<queue empty>", tag, D);
      last = D;
    end else begin
      e = exp_q.pop_front();
      chk(tag, 20'(D), 20'(e));
      last = e;
    end
  endtask

  // launch one run and follow it cycle by cycle; stop_after<0 means run to completion
  task automatic do_run(input string name, input logic [1:0] m, input logic [15:0] s,
                        input int n, input int stop_after, input logic poke_done,
                        input logic [19:0] exp_tog);
    logic [7:0] last;
    @(negedge CLK);
    MODE  = m;
    SEED  = s;
    NCYC  = 16'(n);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    MODE  = 2'b00;
    SEED  = 16'h0000;
    NCYC  = 16'h0000;
    for (int k = 0; k <= n; k++) begin
      pop_chk({name, "_d"}, last);
      if (stop_after >= 0 && k == stop_after) begin
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        chk({name, "_stop_busy"}, 20'(BUSY), 20'd0);
        chk({name, "_stop_done"}, 20'(DONE), 20'd0);
        chk({name, "_stop_dhold"}, 20'(D), 20'(last));
        chk({name, "_stop_tog"}, TOGGLES, exp_tog);
        @(negedge CLK);
        chk({name, "_stop_nodone"}, 20'(DONE), 20'd0);
        return;
      end
      if (k < n) begin
        if (k == 0 || k == n - 1) begin
          chk({name, "_busy"}, 20'(BUSY), 20'd1);
          chk({name, "_done_lo"}, 20'(DONE), 20'd0);
        end
        // a START during RUN must not restart or queue a run
        if (k == 1) START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
      end else begin
        chk({name, "_busy_end"}, 20'(BUSY), 20'd0);
        chk({name, "_done_hi"}, 20'(DONE), 20'd1);
        chk({name, "_tog"}, TOGGLES, exp_tog);
        if (poke_done) START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk({name, "_done_pulse"}, 20'(DONE), 20'd0);
        chk({name, "_idle_busy"}, 20'(BUSY), 20'd0);
        chk({name, "_idle_dhold"}, 20'(D), 20'(last));
        chk({name, "_idle_tog"}, TOGGLES, exp_tog);
      end
    end
  endtask

  initial begin
    RSTB  = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    MODE  = 2'b00;
    SEED  = 16'h0000;
    NCYC  = 16'h0000;
    repeat (2) @(negedge CLK);
    chk("rst_d", 20'(D), 20'd0);
    chk("rst_busy", 20'(BUSY), 20'd0);
    chk("rst_done", 20'(DONE), 20'd0);
    chk("rst_tog", TOGGLES, 20'd0);
    RSTB = 1'b1;

    // STOP while idle is ignored
    STOP = 1'b1;
    @(negedge CLK);
    STOP = 1'b0;
    chk("idle_stop_busy", 20'(BUSY), 20'd0);
    chk("idle_stop_d", 20'(D), 20'd0);

    // invert: 0F,F0,0F,F0,0F, 8 toggles per update
    exp_q = '{8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F};
    do_run("inv", 2'b01, 16'h000F, 4, -1, 1'b1, 20'd32);

    // walking one wraps from 80 back to 01
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    do_run("walk", 2'b11, 16'h1234, 9, -1, 1'b0, 20'd18);

    // LFSR with zero seed: ACE1 -> 59C3
    exp_q = '{8'hE1, 8'hC3};
    do_run("lfsr0", 2'b10, 16'h0000, 1, -1, 1'b0, 20'd2);

    // LFSR with seed 0001: feedback stays 0, so it shifts 01 -> 02 -> 04
    exp_q = '{8'h01, 8'h02, 8'h04};
    do_run("lfsr1", 2'b10, 16'h0001, 2, -1, 1'b0, 20'd4);

    // NCYC=0: straight to DONE, never busy; START in DONE ignored
    exp_q = '{8'hA5};
    do_run("zero", 2'b00, 16'h00A5, 0, -1, 1'b1, 20'd0);

    // abort after 3 updates
    exp_q = '{8'h0F, 8'hF0, 8'h0F, 8'hF0};
    do_run("stop", 2'b01, 16'h000F, 100, 3, 1'b0, 20'd24);

    // reset in the middle of a run
    @(negedge CLK);
    MODE  = 2'b01;
    SEED  = 16'h000F;
    NCYC  = 16'd4;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("mid_busy", 20'(BUSY), 20'd1);
    RSTB = 1'b0;
    @(negedge CLK);
    RSTB = 1'b1;
    chk("mrst_d", 20'(D), 20'd0);
    chk("mrst_busy", 20'(BUSY), 20'd0);
    chk("mrst_done", 20'(DONE), 20'd0);
    chk("mrst_tog", TOGGLES, 20'd0);
    @(negedge CLK);
    chk("mrst_nodone", 20'(DONE), 20'd0);

    exp_q = '{8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F};
    do_run("rerun", 2'b01, 16'h000F, 4, -1, 1'b0, 20'd32);

    chk("queue_empty", 20'(exp_q.size()), 20'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
